mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one simple_mem port between two requesters: instruction fetch (i_*) and load/store (d_*).
- Sequences each access as one valid/ready transaction to the memory.
- Gates mem_wen: the memory writes on any cycle with wen set, whatever valid is.
- Absorbs the memory's registered, sticky ready.
- Converts unanswered requests (out-of-range addresses) into error completions after a timeout.

Parameters:
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready before an error completion is returned (>=2).

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  32  fetch byte address
- i_ready  out  1  fetch completion pulse
- i_rdata  out  32  fetch read data, valid when i_ready
- i_err  out  1  fetch timed out; qualified by i_ready
- d_valid  in  1  data request; held stable until d_ready
- d_wen  in  4  byte write enables; 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_ready  out  1  data completion pulse
- d_rdata  out  32  data read data, valid when d_ready
- d_err  out  1  data timed out; qualified by d_ready
- mem_valid  out  1  to memory valid
- mem_ready  in  1  from memory ready (registered, high while valid held)
- mem_wen  out  4  to memory byte enables
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  from memory read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE. All outputs decode from registered state, grant and counter.
- Reset: state=IDLE, last_grant=I, counter=0.
  - Outputs at reset: mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - i_ready=d_ready=0, i_err=d_err=0, i_rdata=d_rdata=0.
- Reset mid-transaction aborts it: no ready pulse, and mem_valid/mem_wen are low in the cycle after the reset edge.
- Arbitration (in IDLE and DONE):
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant (round-robin), so d wins the first tie after reset.
  - On grant: last_grant is updated, the next state is BUSY_x, and the counter clears.
- BUSY_x:
  - mem_valid=1.
  - mem_addr/mem_wdata/mem_wen come from the granted requester. mem_wen is forced 0 for I.
  - In every state other than BUSY_D, mem_wen=0. mem_addr/mem_wdata are 0 in IDLE/DONE.
- Completion, normal: in BUSY_x with mem_ready=1:
  - x_ready=1 combinationally in that cycle.
  - x_rdata=mem_rdata, x_err=0.
  - Next state is DONE.
- Completion, timeout: in BUSY_x the counter increments each cycle without mem_ready. When counter==TIMEOUT_CYCLES-1 and mem_ready=0:
  - x_ready=1, x_err=1, x_rdata=0.
  - Next state is DONE.
- DONE:
  - mem_valid=0; mem_ready is ignored (it is stale from the previous valid).
  - The arbiter may grant a new request (next state BUSY) or return to IDLE.
- Ungranted requester: ready/err/rdata are 0 every cycle.
- Latency: request seen in cycle N (IDLE) → mem_valid in N+1 → ready in N+2 → DONE in N+3 → next BUSY in N+4 if a request is pending.
  - Steady state: one transaction per 3 cycles.
- Requester contract:
  - Deassert valid, or present a new request, in the cycle after ready.
  - A request still asserted in the DONE cycle is treated as new.
- Counter width is $clog2(TIMEOUT_CYCLES); it saturates at the terminal value.
- Never more than one of i_ready/d_ready high in a cycle.
- Neither requester starves: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Single fetch, i_addr=0x20400004, memory preloaded 0xDEADBEEF:
  - i_valid at cycle 0 → mem_valid cycles 1–2, mem_wen=0.
  - i_ready=1 with i_rdata=0xDEADBEEF, i_err=0 at cycle 2; mem_valid=0 at cycle 3.
- Data write then read, d_addr=0x20400010:
  - Write d_wen=4'b0011, d_wdata=0x12345678 over preload 0xAAAAAAAA.
  - Then a read returns 0xAAAA5678.
  - mem_wen is 0 in every cycle outside BUSY_D.
- Contention, both valid from reset and held:
  - Grant order is D, I, D, I.
  - Readys arrive every 3 cycles.
  - No cycle has both readys set.
- Out-of-range, d_addr=0x00000000, TIMEOUT_CYCLES=16:
  - d_ready=1, d_err=1, d_rdata=0 exactly 16 cycles after mem_valid rises.
  - The next fetch completes normally.
- Stale ready:
  - Back-to-back fetches to 0x20400000 then 0x20400008 (distinct data).
  - The second i_ready occurs only 2 cycles after its mem_valid and carries the second word.
- Reset asserted in the BUSY_D cycle of a write:
  - No d_ready pulse.
  - mem_valid=0 and mem_wen=0 the next cycle.
  - The target word is unchanged beyond the single write cycle already issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of a single simple_mem port.
// Round-robin on ties, one valid/ready transaction per grant, timeout turns silence into an error.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_valid,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    state_e          state_q, state_d;
    logic            last_d_q, last_d_d;  // 1: data side held the most recent grant
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        pick_d    = 1'b0;
        i_ready   = 1'b0;
        i_rdata   = '0;
        i_err     = 1'b0;
        d_ready   = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_valid = 1'b0;
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle, StDone: begin
                // mem_ready is ignored here: in DONE it is left over from the last access
                pick_d = (i_valid && d_valid) ? !last_d_q : d_valid;
                if (i_valid || d_valid) begin
                    state_d  = pick_d ? StBusyD : StBusyI;
                    last_d_d = pick_d;
                    cnt_d    = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusyI: begin
                mem_valid = 1'b1;
                mem_addr  = i_addr;
                if (mem_ready) begin
                    i_ready = 1'b1;
                    i_rdata = mem_rdata;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    i_ready = 1'b1;
                    i_err   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusyD: begin
                mem_valid = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wen   = d_wen;
                if (mem_ready) begin
                    d_ready = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    d_ready = 1'b1;
                    d_err   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-ready memory model.
// Table of single transactions plus hand sequences for contention, stale ready and reset abort.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_ready, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_err;
    logic [3:0]  d_wen;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
        .d_valid(d_valid), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: 64 words at 0x204000xx, registered sticky ready, writes whenever wen is set.
    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:8] == 24'h204000;
    endfunction

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (|mem_wen && in_range(mem_addr)) begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_ready <= mem_valid && in_range(mem_addr);
        mem_rdata <= mem[mem_addr[7:2]];
    end

    typedef struct {
        logic        is_d;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_err;
        int          exp_lat;
    } txn_t;

    txn_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pre_idx  = idx[5:0];
        pre_data = v;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Starts at posedge+1 of an IDLE cycle (cycle 0); returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input string name, input txn_t t);
        int          lat = -1;
        int          c = 0;
        logic        seen = 1'b0;
        logic [31:0] rd = '0;
        logic        er = 1'b0;
        if (t.is_d) begin
            d_valid = 1'b1; d_wen = t.wen; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            i_valid = 1'b1; i_addr = t.addr;
        end
        while (!seen && c < 40) begin
            #1;
            check({name, " mem_valid"}, 32'(mem_valid), 32'(c >= 1));
            check({name, " mem_wen"}, 32'(mem_wen), 32'((c >= 1 && t.is_d) ? t.wen : 4'h0));
            if (c >= 1) check({name, " mem_addr"}, mem_addr, t.addr);
            if (t.is_d) begin
                check({name, " i_ready idle"}, 32'(i_ready), 32'd0);
                if (d_ready) begin seen = 1'b1; rd = d_rdata; er = d_err; end
            end else begin
                check({name, " d_ready idle"}, 32'(d_ready), 32'd0);
                if (i_ready) begin seen = 1'b1; rd = i_rdata; er = i_err; end
            end
            if (seen) lat = c;
            tick();
            c++;
        end
        i_valid = 1'b0; d_valid = 1'b0; d_wen = '0;
        #1;
        check({name, " done mem_valid"}, 32'(mem_valid), 32'd0);
        check({name, " done readys"}, 32'(i_ready | d_ready), 32'd0);
        check({name, " latency"}, 32'(lat), 32'(t.exp_lat));
        check({name, " err"}, 32'(er), 32'(t.exp_err));
        if (t.chk_rdata) check({name, " rdata"}, rd, t.exp_rdata);
        tick();
    endtask

    initial begin
        tbl[0] = '{is_d: 1'b0, wen: 4'h0, addr: 32'h20400004, wdata: 32'h0,
                   exp_rdata: 32'hDEADBEEF, chk_rdata: 1'b1, exp_err: 1'b0, exp_lat: 2};
        tbl[1] = '{is_d: 1'b1, wen: 4'b0011, addr: 32'h20400010, wdata: 32'h12345678,
                   exp_rdata: 32'h0, chk_rdata: 1'b0, exp_err: 1'b0, exp_lat: 2};
        tbl[2] = '{is_d: 1'b1, wen: 4'h0, addr: 32'h20400010, wdata: 32'h0,
                   exp_rdata: 32'hAAAA5678, chk_rdata: 1'b1, exp_err: 1'b0, exp_lat: 2};
        // mem_valid rises in cycle 1, error completion in its 16th cycle
        tbl[3] = '{is_d: 1'b1, wen: 4'h0, addr: 32'h00000000, wdata: 32'h0,
                   exp_rdata: 32'h0, chk_rdata: 1'b1, exp_err: 1'b1, exp_lat: 16};
        tbl[4] = '{is_d: 1'b0, wen: 4'h0, addr: 32'h20400000, wdata: 32'h0,
                   exp_rdata: 32'h11111111, chk_rdata: 1'b1, exp_err: 1'b0, exp_lat: 2};

        reset = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        preload(0, 32'h11111111);
        preload(1, 32'hDEADBEEF);
        preload(2, 32'h22222222);
        preload(4, 32'hAAAAAAAA);
        preload(5, 32'h55555555);
        #1;
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst mem_wen", 32'(mem_wen), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst readys", 32'({i_ready, d_ready}), 32'd0);
        check("rst errs", 32'({i_err, d_err}), 32'd0);
        check("rst i_rdata", i_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        tick();
        reset = 1'b0;

        // Contention from reset: D, I, D, I with a completion every 3 cycles
        i_valid = 1'b1; i_addr = 32'h20400000;
        d_valid = 1'b1; d_addr = 32'h20400004; d_wen = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("rr i_ready c%0d", c), 32'(i_ready), 32'(c == 5 || c == 11));
            check($sformatf("rr d_ready c%0d", c), 32'(d_ready), 32'(c == 2 || c == 8));
            if (c == 1 || c == 7) check($sformatf("rr grant D c%0d", c), mem_addr, 32'h20400004);
            if (c == 4 || c == 10) check($sformatf("rr grant I c%0d", c), mem_addr, 32'h20400000);
            if (c == 2) check("rr d_rdata", d_rdata, 32'hDEADBEEF);
            if (c == 5) check("rr i_rdata", i_rdata, 32'h11111111);
            tick();
        end
        i_valid = 1'b0; d_valid = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_txn($sformatf("vec%0d", k), tbl[k]);

        // Back-to-back fetches: leftover ready in DONE must not complete the second one
        i_valid = 1'b1; i_addr = 32'h20400000;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) i_addr = 32'h20400008;
            #1;
            check($sformatf("b2b i_ready c%0d", c), 32'(i_ready), 32'(c == 2 || c == 5));
            check($sformatf("b2b mem_valid c%0d", c), 32'(mem_valid),
                  32'(c == 1 || c == 2 || c == 4 || c == 5));
            if (c == 2) check("b2b first word", i_rdata, 32'h11111111);
            if (c == 5) check("b2b second word", i_rdata, 32'h22222222);
            tick();
        end
        i_valid = 1'b0;
        tick();

        // Reset during the first BUSY_D cycle of a write
        d_valid = 1'b1; d_wen = 4'b1100; d_addr = 32'h20400014; d_wdata = 32'hCAFEF00D;
        tick();
        reset = 1'b1;
        #1;
        check("abort busy mem_wen", 32'(mem_wen), 32'h0000000C);
        check("abort busy d_ready", 32'(d_ready), 32'd0);
        tick();
        reset = 1'b0; d_valid = 1'b0; d_wen = '0;
        #1;
        check("abort mem_valid", 32'(mem_valid), 32'd0);
        check("abort mem_wen", 32'(mem_wen), 32'd0);
        check("abort d_ready", 32'(d_ready), 32'd0);
        tick();
        #1;
        check("abort d_ready late", 32'(d_ready), 32'd0);
        tick();
        run_txn("abort readback", '{is_d: 1'b1, wen: 4'h0, addr: 32'h20400014, wdata: 32'h0,
                exp_rdata: 32'hCAFE5555, chk_rdata: 1'b1, exp_err: 1'b0, exp_lat: 2});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
